// File: rtl/tpu_run_controller.sv
// -----------------------------------------------------------------------------
// tpu_run_controller
//
// Top-level run sequencer for the 8x8 TPU datapath. One accepted start
// command performs, in order:
//   1. pop one weight set from the Weight FIFO while holding the array
//      weight-reload strobe for WLOAD_CYCLES cycles,
//   2. issue N consecutive Unified Buffer read addresses,
//   3. write N aligned result rows to the Results SRAM, PIPE_LATENCY cycles
//      after each corresponding UB read issue,
//   4. pulse done.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start, abort      run request (sampled only in IDLE), synchronous cancel
//   num_rows          row count N, latched on an accepted start
//   rd_base, wr_base  first UB / Results SRAM address, latched on start
//   fifo_empty        Weight FIFO empty flag, checked only at start
//   fifo_read_enable  Weight FIFO pop
//   we_rl             systolic array weight reload
//   ub_rd, ub_addr    UB read issue valid / address
//   res_we, res_addr  Results SRAM write enable / address
//   busy, done, err   run in progress, completion pulse, rejected-start pulse
//
// Optional feature (macro TPU_RUN_CTRL_PERF_EN):
//   perf_cycles       saturating count of busy cycles for the most recent run
//
// Every output is driven by a flop. Outputs are computed from the next
// state and next counter values, so they line up with the state the FSM
// occupies in the same cycle.
// -----------------------------------------------------------------------------
module tpu_run_controller #(
    parameter int ADDRESSSIZE  = 10,
    parameter int ROWCNT_BW    = 8,
    parameter int WLOAD_CYCLES = 8,
    parameter int PIPE_LATENCY = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ROWCNT_BW-1:0]   num_rows,
    input  logic [ADDRESSSIZE-1:0] rd_base,
    input  logic [ADDRESSSIZE-1:0] wr_base,
    input  logic                   fifo_empty,
    output logic                   fifo_read_enable,
    output logic                   we_rl,
    output logic                   ub_rd,
    output logic [ADDRESSSIZE-1:0] ub_addr,
    output logic                   res_we,
    output logic [ADDRESSSIZE-1:0] res_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   err
`ifdef TPU_RUN_CTRL_PERF_EN
    ,
    output logic [31:0]            perf_cycles
`endif
);

    localparam int WCNT_BW = (WLOAD_CYCLES > 1) ? $clog2(WLOAD_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WLOAD = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [ROWCNT_BW-1:0]   num_q;
    logic [ADDRESSSIZE-1:0] rd_base_q;
    logic [ADDRESSSIZE-1:0] wr_base_q;
    logic [WCNT_BW-1:0]     wcnt, wcnt_nxt;
    logic [ROWCNT_BW-1:0]   rd_idx, rd_idx_nxt;
    logic [ROWCNT_BW-1:0]   wr_idx;

    // Write-back delay line: pipe[k] is ub_rd delayed by k cycles, so
    // pipe[PIPE_LATENCY] is the Results SRAM write enable itself.
    logic [PIPE_LATENCY:1]  pipe, pipe_d, pipe_shift;
    logic                   pre_we;

    logic accept, err_req, kill;

    logic                   fre_d, we_rl_d, ub_rd_d, busy_d, done_d, err_d;
    logic [ADDRESSSIZE-1:0] ub_addr_d, res_addr_d;

    assign accept  = (state == IDLE) && start && !abort && !fifo_empty;
    assign err_req = (state == IDLE) && start && !abort &&  fifo_empty;
    assign kill    = abort && (state != IDLE);

    assign res_we  = pipe[PIPE_LATENCY];

    // pre_we is high the cycle before a write; with a one-cycle latency
    // that is the UB issue strobe itself.
    generate
        if (PIPE_LATENCY == 1) begin : g_lat1
            assign pre_we     = ub_rd;
            assign pipe_shift = ub_rd;
        end else begin : g_latn
            assign pre_we     = pipe[PIPE_LATENCY-1];
            assign pipe_shift = {pipe[PIPE_LATENCY-1:1], ub_rd};
        end
    endgenerate

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = WLOAD;
                end
            end
            WLOAD: begin
                if (wcnt == WCNT_BW'(WLOAD_CYCLES - 1)) begin
                    state_nxt = (num_q == '0) ? DONE : FEED;
                end
            end
            FEED: begin
                if (rd_idx == num_q - ROWCNT_BW'(1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Result rows form one contiguous train, so the last write
                // is the one not followed by another.
                if (res_we && !pre_we) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (kill) begin
            state_nxt = IDLE;
        end
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        wcnt_nxt = '0;
        if (state_nxt == WLOAD && state == WLOAD) begin
            wcnt_nxt = wcnt + WCNT_BW'(1);
        end

        rd_idx_nxt = '0;
        if (state_nxt == FEED && state == FEED) begin
            rd_idx_nxt = rd_idx + ROWCNT_BW'(1);
        end

        fre_d   = (state_nxt == WLOAD) && (state != WLOAD);
        we_rl_d = (state_nxt == WLOAD);
        ub_rd_d = (state_nxt == FEED);
        busy_d  = (state_nxt == WLOAD) || (state_nxt == FEED) ||
                  (state_nxt == DRAIN);
        done_d  = (state_nxt == DONE);
        err_d   = err_req;

        ub_addr_d = '0;
        if (ub_rd_d) begin
            ub_addr_d = rd_base_q + ADDRESSSIZE'(rd_idx_nxt);
        end

        res_addr_d = '0;
        if (pre_we && !kill) begin
            res_addr_d = wr_base_q + ADDRESSSIZE'(wr_idx);
        end

        // Abort discards every row still in flight.
        pipe_d = kill ? '0 : pipe_shift;
    end

    // ----------------------------------------------- datapath and registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q            <= '0;
            rd_base_q        <= '0;
            wr_base_q        <= '0;
            wcnt             <= '0;
            rd_idx           <= '0;
            wr_idx           <= '0;
            pipe             <= '0;
            fifo_read_enable <= 1'b0;
            we_rl            <= 1'b0;
            ub_rd            <= 1'b0;
            ub_addr          <= '0;
            res_addr         <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
        end else begin
            if (accept) begin
                num_q     <= num_rows;
                rd_base_q <= rd_base;
                wr_base_q <= wr_base;
                wr_idx    <= '0;
            end else if (kill) begin
                wr_idx    <= '0;
            end else if (pre_we) begin
                wr_idx    <= wr_idx + ROWCNT_BW'(1);
            end
            wcnt             <= wcnt_nxt;
            rd_idx           <= rd_idx_nxt;
            pipe             <= pipe_d;
            fifo_read_enable <= fre_d;
            we_rl            <= we_rl_d;
            ub_rd            <= ub_rd_d;
            ub_addr          <= ub_addr_d;
            res_addr         <= res_addr_d;
            busy             <= busy_d;
            done             <= done_d;
            err              <= err_d;
        end
    end

`ifdef TPU_RUN_CTRL_PERF_EN
    // Counts cycles with busy high; cleared by an accepted start and held
    // after the run ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if (accept) begin
            perf_cycles <= '0;
        end else if (busy && (perf_cycles != '1)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tpu_run_controller.sv
// -----------------------------------------------------------------------------
// tb_tpu_run_controller
//
// Directed self-checking bench for tpu_run_controller with WLOAD_CYCLES=8
// and PIPE_LATENCY=17. Cycle numbering: the start command is presented in
// cycle 0 and accepted at the edge closing it; cycle c is the period after
// the c-th following edge. Outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_tpu_run_controller;

    localparam int W = 8;
    localparam int L = 17;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] num_rows;
    logic [9:0] rd_base;
    logic [9:0] wr_base;
    logic       fifo_empty;
    logic       fifo_read_enable;
    logic       we_rl;
    logic       ub_rd;
    logic [9:0] ub_addr;
    logic       res_we;
    logic [9:0] res_addr;
    logic       busy;
    logic       done;
    logic       err;
`ifdef TPU_RUN_CTRL_PERF_EN
    logic [31:0] perf_cycles;
`endif

    int checks;
    int errors;
    int cyc;

    tpu_run_controller #(
        .ADDRESSSIZE (10),
        .ROWCNT_BW   (8),
        .WLOAD_CYCLES(W),
        .PIPE_LATENCY(L)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .num_rows        (num_rows),
        .rd_base         (rd_base),
        .wr_base         (wr_base),
        .fifo_empty      (fifo_empty),
        .fifo_read_enable(fifo_read_enable),
        .we_rl           (we_rl),
        .ub_rd           (ub_rd),
        .ub_addr         (ub_addr),
        .res_we          (res_we),
        .res_addr        (res_addr),
        .busy            (busy),
        .done            (done),
        .err             (err)
`ifdef TPU_RUN_CTRL_PERF_EN
        ,
        .perf_cycles     (perf_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // {fifo_read_enable, we_rl, ub_rd, res_we, busy, done, err}
    function automatic logic [6:0] strobes();
        return {fifo_read_enable, we_rl, ub_rd, res_we, busy, done, err};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_strb"}, 32'(strobes()), 32'h0);
        check({tag, "_uba"},  32'(ub_addr),   32'h0);
        check({tag, "_rsa"},  32'(res_addr),  32'h0);
    endtask

    // One complete run. abort_at: cycle during which abort is held (0 = no
    // abort). spur_at: cycle during which a stray start is presented.
    task automatic run(input int n, input logic [9:0] rd, input logic [9:0] wr,
                       input int abort_at, input int spur_at,
                       input logic [31:0] perf_exp);
        int         dcyc;
        int         last;
        logic       k;
        logic       e_fre, e_we, e_ub, e_rw, e_busy, e_done;
        logic [9:0] eua, era;
        dcyc = (n == 0) ? W + 1 : W + n + L + 1;
        last = (abort_at != 0) ? abort_at + 1 : dcyc + 1;

        num_rows = 8'(n);
        rd_base  = rd;
        wr_base  = wr;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        // Scramble the inputs to show the fields were latched.
        num_rows = 8'hA5;
        rd_base  = 10'h155;
        wr_base  = 10'h2AA;

        for (int c = 1; c <= last; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            start = 1'b0;
            abort = 1'b0;
            cyc   = c;

            k      = (abort_at != 0) && (c > abort_at);
            e_fre  = !k && (c == 1);
            e_we   = !k && (c <= W);
            e_ub   = !k && (c > W) && (c <= W + n);
            e_rw   = !k && (n > 0) && (c > W + L) && (c <= W + L + n);
            e_busy = !k && (c < dcyc);
            e_done = !k && (c == dcyc);
            eua    = e_ub ? rd + 10'(c - W - 1)     : 10'h0;
            era    = e_rw ? wr + 10'(c - W - L - 1) : 10'h0;

            check("strb", 32'(strobes()),
                  32'({e_fre, e_we, e_ub, e_rw, e_busy, e_done, 1'b0}));
            check("uba", 32'(ub_addr), 32'(eua));
            check("rsa", 32'(res_addr), 32'(era));
`ifdef TPU_RUN_CTRL_PERF_EN
            if (c == dcyc && abort_at == 0) begin
                check("perf", perf_cycles, perf_exp);
            end
`endif
            if (c == abort_at) begin
                abort = 1'b1;
            end
            if (c == spur_at) begin
                start    = 1'b1;
                num_rows = 8'd3;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        num_rows   = '0;
        rd_base    = '0;
        wr_base    = '0;
        fifo_empty = 1'b0;

        // Reset, then idle with start low.
        step();
        step();
        check_idle("rst");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_idle("idle");
        end

        // Nominal run.
        run(4, 10'h010, 10'h100, 0, 0, 32'd29);

        // Address wrap on both ports.
        run(4, 10'h3FE, 10'h3FF, 0, 0, 32'd29);

        // Start rejected on an empty FIFO, then accepted once it fills.
        fifo_empty = 1'b1;
        num_rows   = 8'd4;
        start      = 1'b1;
        step();
        start      = 1'b0;
        check("err_pulse", 32'(strobes()), 32'h01);
        step();
        check("err_clear", 32'(strobes()), 32'h00);
        fifo_empty = 1'b0;
        run(4, 10'h010, 10'h100, 0, 0, 32'd29);

        // Abort during FEED, then a fresh run right after.
        run(4, 10'h010, 10'h100, 10, 0, 32'd0);
        run(2, 10'h020, 10'h200, 0, 0, 32'd27);

        // Zero rows with a stray start during WLOAD.
        run(0, 10'h005, 10'h006, 0, 5, 32'd8);

        // Asynchronous reset in the middle of a run.
        num_rows = 8'd3;
        start    = 1'b1;
        step();
        start    = 1'b0;
        step();
        step();
        check("pre_arst", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        check_idle("arst");
        step();
        rst = 1'b0;
        step();
        check_idle("post_arst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tpu_run_controller.md
Name: tpu_run_controller

Overview:
- Top-level sequencer for the 8x8 TPU datapath: Weight FIFO, Unified Buffer (UB) SRAM, systolic array, and Results SRAM.
- On a start command it performs four steps in order:
  1. pops one weight set from the Weight FIFO and holds the array weight-reload signal;
  2. streams N consecutive UB read addresses into the data-setup path;
  3. writes N aligned result rows to the Results SRAM after a fixed pipeline latency;
  4. signals completion.
- Replaces the free-running counter and manual enables at TPU top level.

Parameters:
- ADDRESSSIZE, 10, width of UB and Results SRAM addresses.
- ROWCNT_BW, 8, width of the row-count field.
- WLOAD_CYCLES, 8, cycles we_rl is held per weight load (>=1).
- PIPE_LATENCY, 17, cycles from a UB read issue to its aligned result row at the Results SRAM write port (>=1).

Ports:
- clk, input, 1, clock (all logic on the rising edge).
- rst, input, 1, reset, asynchronous, active-high.
- start, input, 1, run request, sampled only in IDLE.
- abort, input, 1, synchronous cancel of a run.
- num_rows, input, ROWCNT_BW, number of input rows N; latched when start is accepted.
- rd_base, input, ADDRESSSIZE, first UB read address; latched when start is accepted.
- wr_base, input, ADDRESSSIZE, first Results SRAM write address; latched when start is accepted.
- fifo_empty, input, 1, Weight FIFO empty flag.
- fifo_read_enable, output, 1, Weight FIFO pop.
- we_rl, output, 1, systolic array weight reload.
- ub_rd, output, 1, UB read-issue valid.
- ub_addr, output, ADDRESSSIZE, UB read address.
- res_we, output, 1, Results SRAM write enable.
- res_addr, output, ADDRESSSIZE, Results SRAM write address.
- busy, output, 1, run in progress.
- done, output, 1, one-cycle completion pulse.
- err, output, 1, one-cycle pulse on a start rejected because the FIFO is empty.

Behaviour:
- All outputs are registered.
- Reset: every output is 0; the FSM is in IDLE; all counters and latched fields are 0.
- FSM states: IDLE, WLOAD, FEED, DRAIN, DONE.
- IDLE, start=1, abort=0, fifo_empty=0:
  - latch num_rows, rd_base, wr_base;
  - go to WLOAD.
- IDLE, start=1 with fifo_empty=1:
  - err=1 for the next cycle;
  - stay in IDLE.
- IDLE, start and abort both 1: abort wins; nothing happens.
- Start accepted at edge T, timing of WLOAD:
  - fifo_read_enable=1 in cycle T+1 only;
  - we_rl=1 in cycles T+1 .. T+WLOAD_CYCLES.
- FEED, cycles T+W+1 .. T+W+N (W = WLOAD_CYCLES):
  - ub_rd=1;
  - ub_addr = rd_base+i for i = 0..N-1, modulo 2^ADDRESSSIZE (wraps).
- Write-back:
  - row i: res_we=1 and res_addr = wr_base+i (wraps) in cycle T+W+1+i+PIPE_LATENCY.
  - Write-back is tracked independently of FEED and may overlap it when PIPE_LATENCY < N.
- FEED goes to DRAIN after its last issue. DRAIN goes to DONE once the last write has been issued.
- DONE:
  - lasts one cycle, T+W+N+PIPE_LATENCY+1;
  - done=1, busy=0;
  - returns to IDLE, where start is accepted again in the same cycle the FSM is back in IDLE.
- busy=1 from T+1 through the last res_we cycle.
- num_rows=0: WLOAD runs normally, then the FSM goes directly to DONE. There is no ub_rd or res_we activity.
- start outside IDLE is ignored.
- abort=1 in any non-IDLE state:
  - next cycle is IDLE;
  - all strobes drop to 0;
  - no done pulse, and pending writes are discarded.
- Reset asserted mid-run: asynchronous return to the reset state.
- fifo_empty is checked only at start. A FIFO that empties later does not affect the run.

Optional Feature:
- Macro TPU_RUN_CTRL_PERF_EN.
- When defined, adds output perf_cycles (32 bits):
  - clears to 0 when start is accepted;
  - increments every cycle while busy=1;
  - holds its value after done or abort until the next accepted start;
  - saturates at 0xFFFFFFFF;
  - resets to 0.
- When undefined, the port and the counter do not exist, and all other behaviour is identical.

Test Plan:
- Reset then idle: rst pulse, then start=0 for 10 cycles -> all outputs remain 0.
- Nominal run: W=8, L=17, start at T=0 with N=4, rd_base=0x010, wr_base=0x100 ->
  - fifo_read_enable at T1;
  - we_rl T1..T8;
  - ub_rd T9..T12 with addresses 0x010..0x013;
  - res_we T26..T29 with addresses 0x100..0x103;
  - done at T30;
  - perf_cycles=29 when the macro is defined.
- Wrap: N=4, rd_base=0x3FE, wr_base=0x3FF -> UB addresses 0x3FE, 0x3FF, 0x000, 0x001; result addresses 0x3FF, 0x000, 0x001, 0x002.
- Empty FIFO: fifo_empty=1, start -> err=1 for one cycle, busy stays 0, no strobes. The same start with fifo_empty=0 then runs normally.
- Abort: abort asserted during FEED at T10 -> at T11 all strobes are 0, busy=0, no done; a new start at T12 is accepted.
- Zero rows and ignored start: N=0 -> we_rl T1..T8, done at T9, no ub_rd or res_we. A start pulse at T5 has no effect.
